// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with busy scoreboard
// Optional same-cycle write->read forwarding when BYPASS_EN is defined.
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*AW-1:0]     wsel,
  input  logic [NWR*DATA_W-1:0] wdat,
  input  logic [NRD*AW-1:0]     rsel,
  output logic [NRD*DATA_W-1:0] rdat,
  output logic [NRD-1:0]        rbusy,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_sel,
  output logic [NREGS-1:0]      busy_vec,
  output logic                  wr_clash
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              clash_q, clash_d;

  logic [AW-1:0]     wa, wb, ra;

  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    clash_d = 1'b0;
    wa      = '0;
    wb      = '0;
    // Ascending port order so the highest enabled port wins a collision.
    for (int i = 0; i < NWR; i++) begin
      wa = wsel[i*AW +: AW];
      if (wen[i] && wa != '0) begin
        regs_d[wa] = wdat[i*DATA_W +: DATA_W];
        busy_d[wa] = 1'b0;
      end
    end
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        wa = wsel[i*AW +: AW];
        wb = wsel[j*AW +: AW];
        if (wen[i] && wen[j] && wa == wb && wa != '0) clash_d = 1'b1;
      end
    end
    // Reserve applied last: it beats a same-cycle release.
    if (rsv_en && rsv_sel != '0) busy_d[rsv_sel] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q  <= '0;
      clash_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      clash_q <= clash_d;
    end
  end

  always_comb begin
    rdat  = '0;
    rbusy = '0;
    ra    = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rsel[i*AW +: AW];
      rdat[i*DATA_W +: DATA_W] = regs_q[ra];
      rbusy[i]                 = busy_q[ra];
`ifdef BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && wsel[j*AW +: AW] == ra && ra != '0) begin
          rdat[i*DATA_W +: DATA_W] = wdat[j*DATA_W +: DATA_W];
          rbusy[i]                 = rsv_en && (rsv_sel == ra);
        end
      end
`endif
    end
  end

  assign busy_vec = busy_q;
  assign wr_clash = clash_q;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - scoreboard bench for register_file_mp
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wen;
  logic [9:0]    wsel;
  logic [63:0]   wdat;
  logic [9:0]    rsel;
  logic [63:0]   rdat;
  logic [1:0]    rbusy;
  logic          rsv_en;
  logic [4:0]    rsv_sel;
  logic [31:0]   busy_vec;
  logic          wr_clash;

  register_file_mp dut (
    .CLK(clk), .RST(rst), .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat), .rbusy(rbusy), .rsv_en(rsv_en),
    .rsv_sel(rsv_sel), .busy_vec(busy_vec), .wr_clash(wr_clash)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_RDAT0 = 3'd0, K_RDAT1 = 3'd1, K_RBUSY0 = 3'd2,
                         K_RBUSY1 = 3'd3, K_BUSYV = 3'd4, K_CLASH = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [2:0] kind, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    wen = '0; wsel = '0; wdat = '0; rsel = '0; rsv_en = 1'b0; rsv_sel = '0;
  endtask

  task automatic drv_wr(input int port, input logic [4:0] a, input logic [31:0] d);
    wen[port]             = 1'b1;
    wsel[port*AW +: AW]   = a;
    wdat[port*DW +: DW]   = d;
  endtask

  task automatic drv_rd(input int port, input logic [4:0] a);
    rsel[port*AW +: AW] = a;
  endtask

  // Compare everything expected for this cycle mid-period, then advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_RDAT0:  check_val("rdat0", rdat[31:0], e.val);
        K_RDAT1:  check_val("rdat1", rdat[63:32], e.val);
        K_RBUSY0: check_val("rbusy0", {31'b0, rbusy[0]}, e.val);
        K_RBUSY1: check_val("rbusy1", {31'b0, rbusy[1]}, e.val);
        K_BUSYV:  check_val("busy_vec", busy_vec, e.val);
        default:  check_val("wr_clash", {31'b0, wr_clash}, e.val);
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state across every address
    for (int r = 0; r < 32; r++) begin
      idle(); drv_rd(0, 5'(r)); drv_rd(1, 5'(31 - r));
      expect_out(K_RDAT0, 32'h0); expect_out(K_RDAT1, 32'h0);
      expect_out(K_BUSYV, 32'h0); expect_out(K_CLASH, 32'h0);
      step();
    end
    idle(); drv_wr(0, 5'd3, 32'hDEADBEEF); step();
    idle(); drv_rd(0, 5'd3); expect_out(K_RDAT0, 32'hDEADBEEF); step();

    // Register 0 is hardwired
    idle(); drv_wr(0, 5'd0, 32'hFFFFFFFF); rsv_en = 1'b1; rsv_sel = 5'd0; drv_rd(0, 5'd0);
    expect_out(K_RDAT0, 32'h0); expect_out(K_RBUSY0, 32'h0); step();
    idle(); drv_rd(0, 5'd0); drv_rd(1, 5'd3);
    expect_out(K_RDAT0, 32'h0); expect_out(K_RDAT1, 32'hDEADBEEF);
    expect_out(K_BUSYV, 32'h0); step();

    // Collision: highest port wins, clash pulses one cycle
    idle(); drv_wr(0, 5'd5, 32'h11); drv_wr(1, 5'd5, 32'h22); expect_out(K_CLASH, 32'h0); step();
    idle(); drv_rd(0, 5'd5); expect_out(K_RDAT0, 32'h22); expect_out(K_CLASH, 32'h1); step();
    idle(); expect_out(K_CLASH, 32'h0); step();
    idle(); drv_wr(0, 5'd0, 32'h1); drv_wr(1, 5'd0, 32'h2); step();
    idle(); expect_out(K_CLASH, 32'h0); drv_wr(0, 5'd6, 32'h66); drv_wr(1, 5'd8, 32'h88); step();
    idle(); drv_rd(0, 5'd6); drv_rd(1, 5'd8);
    expect_out(K_CLASH, 32'h0); expect_out(K_RDAT0, 32'h66); expect_out(K_RDAT1, 32'h88); step();

    // Scoreboard
    idle(); rsv_en = 1'b1; rsv_sel = 5'd7; step();
    idle(); drv_rd(1, 5'd7); expect_out(K_BUSYV, 32'h80); expect_out(K_RBUSY1, 32'h1); step();
    idle(); drv_wr(0, 5'd7, 32'h77); rsv_en = 1'b1; rsv_sel = 5'd7; drv_rd(1, 5'd7);
    expect_out(K_RBUSY1, 32'h1); step();
    idle(); drv_rd(1, 5'd7); expect_out(K_BUSYV, 32'h80); expect_out(K_RDAT1, 32'h77); step();
    idle(); drv_wr(1, 5'd7, 32'h78); drv_rd(1, 5'd7);
`ifdef BYPASS_EN
    expect_out(K_RBUSY1, 32'h0); expect_out(K_RDAT1, 32'h78);
`else
    expect_out(K_RBUSY1, 32'h1); expect_out(K_RDAT1, 32'h77);
`endif
    step();
    idle(); drv_rd(1, 5'd7);
    expect_out(K_BUSYV, 32'h0); expect_out(K_RDAT1, 32'h78); expect_out(K_RBUSY1, 32'h0); step();

    // Bypass / same-cycle visibility
    idle(); drv_wr(0, 5'd9, 32'h1234); step();
    idle(); drv_wr(0, 5'd9, 32'hA5A5); drv_rd(0, 5'd9);
`ifdef BYPASS_EN
    expect_out(K_RDAT0, 32'hA5A5); expect_out(K_RBUSY0, 32'h0);
`else
    expect_out(K_RDAT0, 32'h1234);
`endif
    step();
    idle(); drv_rd(0, 5'd9); expect_out(K_RDAT0, 32'hA5A5); step();

    // Mid-operation reset
    idle(); drv_wr(0, 5'd4, 32'h55); rsv_en = 1'b1; rsv_sel = 5'd4; step();
    idle(); drv_rd(0, 5'd4); expect_out(K_RDAT0, 32'h55); expect_out(K_BUSYV, 32'h10); step();
    idle(); rst = 1'b1; drv_wr(0, 5'd4, 32'h99); drv_wr(1, 5'd4, 32'h98);
    rsv_en = 1'b1; rsv_sel = 5'd9; step();
    rst = 1'b0;
    idle(); drv_rd(0, 5'd4); drv_rd(1, 5'd9);
    expect_out(K_RDAT0, 32'h0); expect_out(K_RDAT1, 32'h0);
    expect_out(K_BUSYV, 32'h0); expect_out(K_CLASH, 32'h0); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
